// File: rtl/stage_mem.sv
// ---------------------------------------------------------------------------
// stage_mem : MEM stage of the 5-stage MIPS pipeline.
//
// Holds the word-addressed data memory, resolves the branch/jump redirect
// towards fetch and registers the MEM/WB pipeline register.
//
// Parameters
//   DEPTH   data memory size in 32-bit words (power of two)
//   ADDR_W  word-index width, log2(DEPTH)
//
// Ports
//   clock, reset       pipeline clock, synchronous active-high reset
//   alu_out            ALU result, byte address for loads/stores
//   data_b             store data
//   M                  1 = store
//   wbi                [1] reg_write, [0] mem_to_reg (load)
//   regaddr            destination register
//   zero               ALU zero flag
//   is_jump            unconditional jump
//   branch_eq          branch if equal
//   branch_inc         branch if not equal
//   jump_address       redirect target
//   pc_src, pc_target  combinational redirect to fetch
//   wbi_o, regaddr_o,
//   alu_out_o,
//   mem_data_o         MEM/WB register
//   mem_fault          sticky out-of-range / unaligned access flag
//
// Optional feature (macro STAGE_MEM_DEBUG_PORT_EN):
//   dbg_addr / dbg_data give the debug unit a combinational read port into
//   the data memory. It does not influence pipeline behaviour.
// ---------------------------------------------------------------------------
module stage_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       data_b,
  input  logic              M,
  input  logic [1:0]        wbi,
  input  logic [4:0]        regaddr,
  input  logic              zero,
  input  logic              is_jump,
  input  logic              branch_eq,
  input  logic              branch_inc,
  input  logic [31:0]       jump_address,
`ifdef STAGE_MEM_DEBUG_PORT_EN
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data,
`endif
  output logic              pc_src,
  output logic [31:0]       pc_target,
  output logic [1:0]        wbi_o,
  output logic [4:0]        regaddr_o,
  output logic [31:0]       alu_out_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_fault
);

  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_W-1:0] w_index;
  logic              w_in_range;
  logic              w_aligned;
  logic              w_addr_ok;
  logic              w_access;
  logic              w_fault_now;
  logic              w_we;
  logic [31:0]       w_rd_data;

  // Redirect is purely combinational so fetch can react in the same cycle,
  // including while reset is asserted.
  assign pc_src    = is_jump | (branch_eq & zero) | (branch_inc & ~zero);
  assign pc_target = jump_address;

  assign w_index     = alu_out[ADDR_W+1:2];
  assign w_in_range  = (alu_out[31:ADDR_W+2] == '0);
  assign w_aligned   = (alu_out[1:0] == 2'b00);
  assign w_addr_ok   = w_in_range & w_aligned;
  assign w_access    = M | wbi[0];
  assign w_fault_now = w_access & ~w_addr_ok;
  assign w_we        = M & w_addr_ok & ~reset;

  // Read is taken from the array before this edge's write lands, so a
  // simultaneous load+store returns the old word.
  assign w_rd_data = w_addr_ok ? r_mem[w_index] : 32'd0;

  // Memory contents survive reset; only the write enable is gated by it.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[w_index] <= data_b;
    end
  end

`ifdef STAGE_MEM_DEBUG_PORT_EN
  assign dbg_data = r_mem[dbg_addr];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      wbi_o      <= 2'b00;
      regaddr_o  <= 5'd0;
      alu_out_o  <= 32'd0;
      mem_data_o <= 32'd0;
      mem_fault  <= 1'b0;
    end else begin
      wbi_o      <= wbi;
      regaddr_o  <= regaddr;
      alu_out_o  <= alu_out;
      mem_data_o <= w_rd_data;
      // Sticky: once any bad access is seen, hold until reset.
      if (w_fault_now) begin
        mem_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

  localparam int DEPTH = 256;

  logic        clock;
  logic        reset;
  logic [31:0] alu_out;
  logic [31:0] data_b;
  logic        m_in;
  logic [1:0]  wbi;
  logic [4:0]  regaddr;
  logic        zero;
  logic        is_jump;
  logic        branch_eq;
  logic        branch_inc;
  logic [31:0] jump_address;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [1:0]  wbi_o;
  logic [4:0]  regaddr_o;
  logic [31:0] alu_out_o;
  logic [31:0] mem_data_o;
  logic        mem_fault;
`ifdef STAGE_MEM_DEBUG_PORT_EN
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  stage_mem #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_out      (alu_out),
    .data_b       (data_b),
    .M            (m_in),
    .wbi          (wbi),
    .regaddr      (regaddr),
    .zero         (zero),
    .is_jump      (is_jump),
    .branch_eq    (branch_eq),
    .branch_inc   (branch_inc),
    .jump_address (jump_address),
`ifdef STAGE_MEM_DEBUG_PORT_EN
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
`endif
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .wbi_o        (wbi_o),
    .regaddr_o    (regaddr_o),
    .alu_out_o    (alu_out_o),
    .mem_data_o   (mem_data_o),
    .mem_fault    (mem_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_known [DEPTH];
  logic [1:0]  exp_wbi;
  logic [4:0]  exp_regaddr;
  logic [31:0] exp_alu;
  logic [31:0] exp_data;
  bit          exp_data_vld;
  bit          exp_fault;
  bit          cmp_en;

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_known[i] = 0;
    exp_fault = 0;
    cmp_en = 0;
  end

  always @(posedge clock) begin
    int unsigned idx;
    bit ok;
    idx = alu_out / 4;
    ok  = (alu_out < DEPTH * 4) && (alu_out % 4 == 0);
    if (reset) begin
      exp_wbi = 0; exp_regaddr = 0; exp_alu = 0; exp_data = 0;
      exp_data_vld = 1; exp_fault = 0;
    end else begin
      exp_wbi     = wbi;
      exp_regaddr = regaddr;
      exp_alu     = alu_out;
      exp_data_vld = wbi[0] && (!ok || mdl_known[idx]);
      exp_data    = ok ? mdl_mem[idx] : 32'd0;
      if ((m_in || wbi[0]) && !ok) exp_fault = 1;
      if (m_in && ok) begin
        mdl_mem[idx]   = data_b;
        mdl_known[idx] = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("wbi_o", {30'd0, wbi_o}, {30'd0, exp_wbi});
      chk("regaddr_o", {27'd0, regaddr_o}, {27'd0, exp_regaddr});
      chk("alu_out_o", alu_out_o, exp_alu);
      chk("mem_fault", {31'd0, mem_fault}, {31'd0, exp_fault});
      if (exp_data_vld) chk("mem_data_o", mem_data_o, exp_data);
      chk("pc_src", {31'd0, pc_src},
          {31'd0, is_jump | (branch_eq & zero) | (branch_inc & ~zero)});
      chk("pc_target", pc_target, jump_address);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1; alu_out = 0; data_b = 0; m_in = 0; wbi = 0; regaddr = 0;
    zero = 0; is_jump = 0; branch_eq = 0; branch_inc = 0; jump_address = 0;
`ifdef STAGE_MEM_DEBUG_PORT_EN
    dbg_addr = 0;
`endif
    tick();
    cmp_en = 1;
    reset = 0;

    // Preload every word with a known pattern: word i = 0xC0ii1234.
    for (int i = 0; i < DEPTH; i++) begin
      m_in = 1; wbi = 0; alu_out = i * 4; data_b = 32'hC0001234 | (i << 16);
      tick();
    end
    m_in = 0;

    // Reset with a store pending: the store must be dropped.
    reset = 1; m_in = 1; alu_out = 32'h10; data_b = 32'hAA; wbi = 2'b11; regaddr = 3;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_wbi_o", {30'd0, wbi_o}, 32'd0);
      chk("rst_regaddr_o", {27'd0, regaddr_o}, 32'd0);
      chk("rst_fault", {31'd0, mem_fault}, 32'd0);
    end
    reset = 0; m_in = 0; wbi = 2'b01; regaddr = 0; alu_out = 32'h10;
    tick();
    chk("rst_store_dropped", mem_data_o, 32'hC0041234);

    // Store then load the same word on the next cycle.
    m_in = 1; alu_out = 32'h14; data_b = 32'hDEADBEEF; wbi = 2'b00; regaddr = 0;
    tick();
    m_in = 0; wbi = 2'b11; alu_out = 32'h14; regaddr = 9;
    tick();
    chk("ld_data", mem_data_o, 32'hDEADBEEF);
    chk("ld_regaddr", {27'd0, regaddr_o}, 32'd9);
    chk("ld_wbi", {30'd0, wbi_o}, 32'd3);
    chk("ld_alu", alu_out_o, 32'h14);

    // Redirect logic, checked in the same cycle.
    wbi = 0; alu_out = 0; zero = 1; branch_eq = 1; jump_address = 32'd11;
    #1;
    chk("beq_taken", {31'd0, pc_src}, 32'd1);
    chk("pc_target", pc_target, 32'd11);
    branch_eq = 0; branch_inc = 1;
    #1;
    chk("bne_not_taken", {31'd0, pc_src}, 32'd0);
    branch_inc = 0; zero = 0; is_jump = 1;
    #1;
    chk("jump_taken", {31'd0, pc_src}, 32'd1);
    is_jump = 0;
    tick();

    // Unaligned store: memory untouched, fault sticky until reset.
    m_in = 1; alu_out = 32'h16; data_b = 32'h12345678;
    tick();
    chk("unal_fault", {31'd0, mem_fault}, 32'd1);
    m_in = 0; wbi = 2'b01; alu_out = 32'h14;
    tick();
    chk("unal_mem_kept", mem_data_o, 32'hDEADBEEF);
    wbi = 0; alu_out = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("fault_sticky", {31'd0, mem_fault}, 32'd1);
    end
    reset = 1;
    tick();
    chk("fault_cleared", {31'd0, mem_fault}, 32'd0);
    reset = 0;

    // Out-of-range load.
    wbi = 2'b01; alu_out = 32'h400; regaddr = 2;
    tick();
    chk("oor_data", mem_data_o, 32'd0);
    chk("oor_fault", {31'd0, mem_fault}, 32'd1);
    chk("oor_alu", alu_out_o, 32'h400);
    reset = 1; wbi = 0; alu_out = 0;
    tick();
    reset = 0;

`ifdef STAGE_MEM_DEBUG_PORT_EN
    m_in = 1; alu_out = 32'h20; data_b = 32'h5; dbg_addr = 8;
    tick();
    m_in = 0;
    chk("dbg_data", dbg_data, 32'h5);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 39);
      if (r == 0)      alu_out = ($urandom_range(0, 31) * 4) + $urandom_range(1, 3);
      else if (r == 1) alu_out = 32'h400 + $urandom_range(0, 4095);
      else             alu_out = $urandom_range(0, 31) * 4;
      data_b       = $urandom;
      m_in         = ($urandom_range(0, 2) == 0);
      wbi          = 2'($urandom_range(0, 3));
      regaddr      = 5'($urandom_range(0, 31));
      zero         = 1'($urandom_range(0, 1));
      is_jump      = ($urandom_range(0, 4) == 0);
      branch_eq    = 1'($urandom_range(0, 1));
      branch_inc   = 1'($urandom_range(0, 1));
      jump_address = $urandom;
      reset        = ($urandom_range(0, 59) == 0);
`ifdef STAGE_MEM_DEBUG_PORT_EN
      dbg_addr     = 8'($urandom_range(0, 255));
`endif
      tick();
    end

    reset = 0; m_in = 0; wbi = 0;
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of stage_exe; consumes its EX/MEM outputs.
- Holds the word-addressed data memory and resolves branch/jump redirect to fetch.
- Registers the MEM/WB pipeline register consumed by the write-back stage.

Parameters:
- DEPTH, 256, data memory size in 32-bit words (power of two).
- ADDR_W, 8, word-index width, equal to log2(DEPTH).

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- alu_out  in  32  ALU result (out) from stage_exe; byte address for loads/stores
- data_b  in  32  store data (data_b_o from stage_exe)
- M  in  1  1 = store, 0 = no store
- wbi  in  2  [1] reg_write, [0] mem_to_reg
- regaddr  in  5  destination register
- zero  in  1  ALU zero flag
- is_jump  in  1  unconditional jump
- branch_eq  in  1  branch if equal
- branch_inc  in  1  branch if not equal
- jump_address  in  32  target from stage_exe
- pc_src  out  1  combinational redirect to fetch
- pc_target  out  32  combinational, equals jump_address
- wbi_o  out  2  MEM/WB registered wbi
- regaddr_o  out  5  MEM/WB registered regaddr
- alu_out_o  out  32  MEM/WB registered alu_out
- mem_data_o  out  32  MEM/WB registered load data
- mem_fault  out  1  sticky fault flag

Behaviour:
- pc_src = is_jump | (branch_eq & zero) | (branch_inc & ~zero), purely combinational; pc_target = jump_address. Both remain valid during reset.
- Word index = alu_out[ADDR_W+1:2]. In range when alu_out[31:ADDR_W+2] == 0. Aligned when alu_out[1:0] == 0.
- Store: on a rising edge with M=1, reset=0, in range and aligned, mem[index] <= data_b. Otherwise no memory write.
- Load: read is combinational from the array and captured into mem_data_o at the same edge. Load latency is 1 cycle, matching all other MEM/WB fields.
- A load of a word stored in the previous cycle returns the new data, because the write committed at the earlier edge.
- Out-of-range or unaligned access: mem_data_o captures 0. An access is a store (M=1) or a load (wbi[0]=1).
- Store with M=1 and wbi[0]=1 simultaneously: the store happens, and mem_data_o captures the pre-write word (read-before-write).
- mem_fault: set at the edge following any out-of-range or unaligned access. It stays set until reset. The access that faults still propagates wbi/regaddr/alu_out normally.
- MEM/WB register: on every non-reset edge, wbi_o <= wbi, regaddr_o <= regaddr, alu_out_o <= alu_out; mem_data_o is updated as described above.
- Reset (synchronous, may be asserted mid-stream):
  - wbi_o = 0, regaddr_o = 0, alu_out_o = 0, mem_data_o = 0, mem_fault = 0.
  - A store presented in a reset cycle is dropped.
  - Memory contents are not cleared by reset.
- No stall or flush inputs: one instruction per cycle. Flush of younger stages is fetch/decode's responsibility, using pc_src.

Optional Feature:
- Macro: STAGE_MEM_DEBUG_PORT_EN.
- Defined: adds input dbg_addr [ADDR_W-1:0] and output dbg_data [31:0].
  - dbg_data = mem[dbg_addr], combinational, for the debug unit to dump data memory.
  - The port has no effect on pipeline behaviour.
  - Reads a word stored at edge N from the cycle after edge N.
- Not defined: ports absent; memory reachable only through loads.

Test Plan:
- Reset held 2 cycles with M=1, alu_out=0x10, data_b=0xAA; release, then load 0x10 → wbi_o=00, regaddr_o=0, mem_fault=0 during reset; load does not return 0xAA (store dropped).
- Store M=1, alu_out=0x14, data_b=0xDEADBEEF; next cycle load wbi=11, alu_out=0x14, regaddr=9 → one edge later mem_data_o=0xDEADBEEF, regaddr_o=9, wbi_o=11, alu_out_o=0x14.
- alu_out=0, zero=1 with branch_eq=1, jump_address=11 → pc_src=1, pc_target=11 same cycle; zero=1 with branch_inc=1 → pc_src=0; is_jump=1, zero=0 → pc_src=1.
- Store to alu_out=0x16 (unaligned) then load 0x14 → memory unchanged, mem_fault=1 after the edge and stays 1 for 10 cycles until reset.
- Load alu_out=0x400 (out of range at DEPTH=256) → mem_data_o=0, mem_fault=1, alu_out_o=0x400.
- With STAGE_MEM_DEBUG_PORT_EN: store 0x5 to alu_out=0x20, dbg_addr=8 → dbg_data=0x5 from the following cycle.
